// File: rtl/sha256_msg_sched_if.sv
// Bus bundle for the SHA-256 message schedule stage: preprocessor word stream in,
// schedule words and status out. The master drives words, the slave is the scheduler.
`timescale 1ns/1ps
interface sha256_msg_sched_if;
    logic        valid_i;
    logic [31:0] M_i;
    logic        w_valid_o;
    logic [31:0] W_o;
    logic [5:0]  t_o;
    logic        last_o;
    logic        busy_o;
    logic        ovf_o;

    modport master (
        output valid_i, M_i,
        input  w_valid_o, W_o, t_o, last_o, busy_o, ovf_o
    );

    modport slave (
        input  valid_i, M_i,
        output w_valid_o, W_o, t_o, last_o, busy_o, ovf_o
    );
endinterface

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: passes W[0..15] through, then generates W[16..ROUNDS-1]
// from a 16-entry circular window. Define SCHED_DBUF_EN to add an input FIFO.
`timescale 1ns/1ps
module sha256_msg_sched #(
    parameter int unsigned ROUNDS     = 64,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    sha256_msg_sched_if.slave bus
);
    if (ROUNDS < 17 || ROUNDS > 64 || FIFO_DEPTH < 2) begin : g_param_check
        $error("sha256_msg_sched: illegal ROUNDS or FIFO_DEPTH");
    end

    typedef enum logic {LOAD = 1'b0, GEN = 1'b1} state_e;

    state_e      state_q, state_d;
    logic [6:0]  t_q, t_d;
    logic [31:0] win_q [16];
    logic        win_we;
    logic [31:0] win_wdata;

    logic        w_valid_q, w_valid_d;
    logic [31:0] W_q, W_d;
    logic [5:0]  t_out_q, t_out_d;
    logic        last_q, last_d;
    logic        busy_q, busy_d;
    logic        ovf_q, ovf_d;

    logic        ld_valid;
    logic [31:0] ld_word;
    logic        in_drop;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

`ifdef SCHED_DBUF_EN
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]   fifo_q [FIFO_DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q;
    logic          push, pop, full, empty;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CW'(FIFO_DEPTH));
    assign pop      = (state_q == LOAD) && !empty;
    assign push     = bus.valid_i && (!full || pop);
    assign in_drop  = bus.valid_i && full && !pop;
    assign ld_valid = pop;
    assign ld_word  = fifo_q[rd_q];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_q] <= bus.M_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                wr_q <= (wr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_q + PW'(1);
            end
            if (pop) begin
                rd_q <= (rd_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end
`else
    assign ld_valid = bus.valid_i && (state_q == LOAD);
    assign ld_word  = bus.M_i;
    assign in_drop  = bus.valid_i && (state_q == GEN);
`endif

    // Window slot t mod 16 holds W[t-16]; W[t-15] sits one slot ahead of it.
    logic [3:0]  ti;
    logic [31:0] gen_word;

    assign ti       = t_q[3:0];
    assign gen_word = sig1(win_q[ti - 4'd2]) + win_q[ti - 4'd7]
                    + sig0(win_q[ti + 4'd1]) + win_q[ti];

    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        win_we    = 1'b0;
        win_wdata = ld_word;
        w_valid_d = 1'b0;
        W_d       = '0;
        t_out_d   = '0;
        last_d    = 1'b0;
        busy_d    = 1'b0;
        ovf_d     = ovf_q | in_drop;

        case (state_q)
            LOAD: begin
                if (ld_valid) begin
                    win_we    = 1'b1;
                    w_valid_d = 1'b1;
                    W_d       = ld_word;
                    t_out_d   = t_q[5:0];
                    t_d       = t_q + 7'd1;
                    if (t_q == 7'd15) begin
                        state_d = GEN;
                    end
                end
            end
            GEN: begin
                // t == ROUNDS is the cycle last_o is on the outputs; still GEN, so input drops.
                if (t_q == 7'(ROUNDS)) begin
                    state_d = LOAD;
                    t_d     = '0;
                end else begin
                    win_we    = 1'b1;
                    win_wdata = gen_word;
                    w_valid_d = 1'b1;
                    W_d       = gen_word;
                    t_out_d   = t_q[5:0];
                    busy_d    = 1'b1;
                    last_d    = (t_q == 7'(ROUNDS - 1));
                    t_d       = t_q + 7'd1;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= LOAD;
            t_q       <= '0;
            w_valid_q <= 1'b0;
            W_q       <= '0;
            t_out_q   <= '0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
            for (int unsigned i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            t_q       <= t_d;
            w_valid_q <= w_valid_d;
            W_q       <= W_d;
            t_out_q   <= t_out_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
            if (win_we) begin
                win_q[ti] <= win_wdata;
            end
        end
    end

    assign bus.w_valid_o = w_valid_q;
    assign bus.W_o       = W_q;
    assign bus.t_o       = t_out_q;
    assign bus.last_o    = last_q;
    assign bus.busy_o    = busy_q;
    assign bus.ovf_o     = ovf_q;
endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench for sha256_msg_sched: directed blocks plus random words and gaps,
// checked against a full-array SHA-256 schedule model.
`timescale 1ns/1ps
module tb_sha256_msg_sched;
    typedef logic [31:0] blk_t [16];

    typedef struct packed {
        int unsigned cyc;
        logic [31:0] w;
        logic [5:0]  t;
        logic        last;
        logic        busy;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n;

    sha256_msg_sched_if bus ();

    sha256_msg_sched #(
        .ROUNDS     (64),
        .FIFO_DEPTH (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_chk    = 0;
    int unsigned n_err    = 0;
    int unsigned cyc_n    = 0;
    int unsigned idle_bad = 0;
    bit          mon_en   = 1'b0;
    rec_t        out_q [$];
    logic [31:0] expw [64];
    logic [31:0] capw [64];
    int unsigned gap_used [16];
    blk_t        abc, b2, ones;

    // Outputs are captured mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        rec_t r;
        cyc_n++;
        if (mon_en) begin
            if (bus.w_valid_o === 1'b1) begin
                r.cyc  = cyc_n;
                r.w    = bus.W_o;
                r.t    = bus.t_o;
                r.last = bus.last_o;
                r.busy = bus.busy_o;
                out_q.push_back(r);
            end else if (bus.W_o !== '0 || bus.t_o !== '0 || bus.last_o !== 1'b0 || bus.busy_o !== 1'b0) begin
                idle_bad++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int unsigned n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    task automatic build_ref(input blk_t m);
        longint unsigned acc;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                expw[t] = m[t];
            end else begin
                acc = longint'(rr(expw[t-2], 17) ^ rr(expw[t-2], 19) ^ (expw[t-2] >> 10))
                    + longint'(expw[t-7])
                    + longint'(rr(expw[t-15], 7) ^ rr(expw[t-15], 18) ^ (expw[t-15] >> 3))
                    + longint'(expw[t-16]);
                expw[t] = 32'(acc % 64'h1_0000_0000);
            end
        end
    endtask

    task automatic drive_block(input blk_t m, input int unsigned gmin, input int unsigned gmax);
        for (int k = 0; k < 16; k++) begin
            bus.valid_i = 1'b1;
            bus.M_i     = m[k];
            tick();
            bus.valid_i = 1'b0;
            bus.M_i     = $urandom;
            gap_used[k] = $urandom_range(gmax, gmin);
            repeat (gap_used[k]) tick();
        end
    endtask

    task automatic wait_outputs(input int unsigned n, input int unsigned budget);
        int unsigned k = 0;
        while (out_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk("wait_outputs", 64'(out_q.size() >= n), 64'd1);
    endtask

    task automatic check_block(input string tag, input bit spacing);
        rec_t        r;
        int unsigned prev = 0;
        wait_outputs(64, 300);
        for (int i = 0; i < 64; i++) begin
            if (out_q.size() == 0) break;
            r = out_q.pop_front();
            capw[i] = r.w;
            chk($sformatf("%s W[%0d] {t,last,busy,W}", tag, i),
                64'({r.t, r.last, r.busy, r.w}),
                64'({6'(i), (i == 63), (i >= 16), expw[i]}));
            if (i >= 16 || (spacing && i > 0)) begin
                chk($sformatf("%s spacing t=%0d", tag, i), 64'(r.cyc - prev),
                    (i >= 16) ? 64'd1 : 64'(gap_used[i-1] + 1));
            end
            prev = r.cyc;
        end
    endtask

    function automatic logic [63:0] out_vec();
        return 64'({bus.w_valid_o, bus.busy_o, bus.last_o, bus.ovf_o, bus.t_o, bus.W_o});
    endfunction

    initial begin
        int unsigned k;
        int unsigned bad;

        for (int i = 0; i < 16; i++) begin
            abc[i]  = '0;
            ones[i] = 32'hFFFF_FFFF;
        end
        abc[0]  = 32'h6162_6380;
        abc[15] = 32'h0000_0018;

        rst_n       = 1'b0;
        bus.valid_i = 1'b0;
        bus.M_i     = '0;
        repeat (3) tick();
        chk("reset outputs", out_vec(), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("post-reset idle", out_vec(), 64'd0);
        mon_en = 1'b1;

        // FIPS "abc" block, back-to-back
        build_ref(abc);
        drive_block(abc, 0, 0);
        check_block("abc", 1'b1);
        chk("abc W0",  64'(capw[0]),  64'h6162_6380);
        chk("abc W15", 64'(capw[15]), 64'h0000_0018);
        chk("abc W16", 64'(capw[16]), 64'h6162_6380);
        chk("abc W17", 64'(capw[17]), 64'h000F_0000);
        chk("abc W63", 64'(capw[63]), 64'h12B1_EDEB);
        chk("abc ovf", 64'(bus.ovf_o), 64'd0);

        // Same block with 2-cycle gaps
        drive_block(abc, 2, 2);
        check_block("abc_gap2", 1'b1);

        // Random words, random gaps
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 16; i++) b2[i] = $urandom;
            build_ref(b2);
            drive_block(b2, 0, 3);
            check_block($sformatf("rand%0d", b), 1'b1);
        end

        // Second block arriving 5 cycles into GEN
        for (int i = 0; i < 16; i++) b2[i] = $urandom;
        build_ref(abc);
        drive_block(abc, 0, 0);
        repeat (5) tick();
        drive_block(b2, 0, 0);
        check_block("ovl_b1", 1'b0);
`ifdef SCHED_DBUF_EN
        build_ref(b2);
        check_block("ovl_b2", 1'b1);
        chk("ovl ovf", 64'(bus.ovf_o), 64'd0);
`else
        chk("ovl ovf set", 64'(bus.ovf_o), 64'd1);
        repeat (20) tick();
        chk("ovl dropped words", 64'(out_q.size()), 64'd0);
        out_q.delete();
        build_ref(b2);
        drive_block(b2, 0, 1);
        check_block("after_ovl", 1'b1);
        chk("ovf held", 64'(bus.ovf_o), 64'd1);
`endif

        // Reset in the middle of LOAD
        for (int i = 0; i < 7; i++) begin
            bus.valid_i = 1'b1;
            bus.M_i     = $urandom;
            tick();
        end
        bus.valid_i = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("reset mid-LOAD", out_vec(), 64'd0);
        rst_n = 1'b1;
        tick();
        out_q.delete();
        build_ref(abc);
        drive_block(abc, 0, 0);
        check_block("after_rst_load", 1'b1);

        // Reset while t=30 is on the outputs
        drive_block(abc, 0, 0);
        k = 0;
        while (!(bus.w_valid_o === 1'b1 && bus.t_o === 6'd30) && k < 100) begin
            tick();
            k++;
        end
        chk("reached t=30", 64'(bus.t_o), 64'd30);
        rst_n = 1'b0;
        tick();
        chk("reset mid-GEN", out_vec(), 64'd0);
        rst_n = 1'b1;
        repeat (60) tick();
        bad = 0;
        foreach (out_q[i]) if (out_q[i].last || out_q[i].t > 6'd30) bad++;
        chk("partial block discarded", 64'(bad), 64'd0);
        out_q.delete();
        drive_block(abc, 0, 0);
        check_block("after_rst_gen", 1'b1);
        chk("after_rst_gen W16", 64'(capw[16]), 64'h6162_6380);

        // All-ones block: s1=0x003FFFFF, s0=0x1FFFFFFF, plus two 0xFFFFFFFF, mod 2^32
        build_ref(ones);
        drive_block(ones, 0, 0);
        check_block("ones", 1'b1);
        chk("ones W16 wrap", 64'(capw[16]), 64'h203F_FFFC);

        repeat (3) tick();
        chk("idle outputs zero", 64'(idle_bad), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
